global_tag_router: RTL and testbench

Sits directly downstream of the BD tag splitter's global-tag output. Consumes tag/count words whose global tag is not go-home. Looks up each global tag in a programmable fan-out table and emits one output word per destination bit set in the table entry. Words whose entry is zero are dropped and counted.

---
 rtl/global_tag_router.sv | 144 ++++++++++++++
 tb/tb_global_tag_router.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/global_tag_router.sv
`default_nettype none
// ============================================================================
// Module   : global_tag_router
// Purpose  : Fans each global-tagged word out to the destinations selected by
//            a programmable per-tag mask; zero-mask words are dropped/counted.
// Revision : 1.0 - initial release
// ============================================================================
module global_tag_router #(
  parameter int NGLOBAL = 8,
  parameter int NTAG    = 11,
  parameter int NCT     = 9,
  parameter int NDEST   = 4,
  parameter int NDROP   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_v,
  output logic                       in_a,
  input  logic [NGLOBAL-1:0]         in_global_tag,
  input  logic [NTAG-1:0]            in_tag,
  input  logic [NCT-1:0]             in_ct,
  output logic                       out_v,
  input  logic                       out_a,
  output logic [$clog2(NDEST)-1:0]   out_dest,
  output logic [NTAG-1:0]            out_tag,
  output logic [NCT-1:0]             out_ct,
  input  logic                       conf_we,
  input  logic [NGLOBAL-1:0]         conf_addr,
  input  logic [NDEST-1:0]           conf_mask,
  output logic [NDROP-1:0]           drop_count
);

  localparam int DEPTH = 2 ** NGLOBAL;
  localparam int DW    = $clog2(NDEST);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    EMIT   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NDEST-1:0]   table_q [DEPTH];
  logic [NDEST-1:0]   table_d [DEPTH];
  logic [NGLOBAL-1:0] gt_q, gt_d;
  logic [NTAG-1:0]    tag_q, tag_d;
  logic [NCT-1:0]     ct_q, ct_d;
  logic [NDEST-1:0]   rem_q, rem_d;
  logic [NDROP-1:0]   drop_q, drop_d;

  logic [NDEST-1:0]   lookup_mask;
  logic [NDEST-1:0]   rem_next;
  logic [DW-1:0]      low_idx;

  // table_q is the pre-edge value, so a same-cycle write is invisible to LOOKUP.
  always_comb begin
    table_d = table_q;
    if (conf_we) begin
      table_d[conf_addr] = conf_mask;
    end
  end

  always_comb begin
    low_idx = '0;
    for (int i = NDEST - 1; i >= 0; i--) begin
      if (rem_q[i]) begin
        low_idx = DW'(i);
      end
    end
  end

  assign lookup_mask = table_q[gt_q];
  assign rem_next    = rem_q & (rem_q - NDEST'(1));

  always_comb begin
    state_d = state_q;
    gt_d    = gt_q;
    tag_d   = tag_q;
    ct_d    = ct_q;
    rem_d   = rem_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        if (in_v) begin
          gt_d    = in_global_tag;
          tag_d   = in_tag;
          ct_d    = in_ct;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        rem_d = lookup_mask;
        if (lookup_mask == '0) begin
          if (drop_q != '1) begin
            drop_d = drop_q + NDROP'(1);
          end
          state_d = IDLE;
        end else begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_a) begin
          rem_d = rem_next;
          if (rem_next == '0) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gt_q    <= '0;
      tag_q   <= '0;
      ct_q    <= '0;
      rem_q   <= '0;
      drop_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      gt_q    <= gt_d;
      tag_q   <= tag_d;
      ct_q    <= ct_d;
      rem_q   <= rem_d;
      drop_q  <= drop_d;
      table_q <= table_d;
    end
  end

  assign in_a       = (state_q == IDLE);
  assign out_v      = (state_q == EMIT);
  assign out_dest   = low_idx;
  assign out_tag    = tag_q;
  assign out_ct     = ct_q;
  assign drop_count = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_global_tag_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_global_tag_router
// Purpose  : Self-checking bench: vector table, corner sequences, random words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_global_tag_router;

  // Narrow drop counter so saturation is reachable in a short run.
  localparam int TB_NDROP = 8;
  localparam int DROP_MAX = (1 << TB_NDROP) - 1;

  logic        clk;
  logic        reset;
  logic        in_v;
  logic        in_a;
  logic [7:0]  in_global_tag;
  logic [10:0] in_tag;
  logic [8:0]  in_ct;
  logic        out_v;
  logic        out_a;
  logic [1:0]  out_dest;
  logic [10:0] out_tag;
  logic [8:0]  out_ct;
  logic        conf_we;
  logic [7:0]  conf_addr;
  logic [3:0]  conf_mask;
  logic [TB_NDROP-1:0] drop_count;

  global_tag_router #(
    .NGLOBAL(8), .NTAG(11), .NCT(9), .NDEST(4), .NDROP(TB_NDROP)
  ) dut (
    .clk(clk), .reset(reset),
    .in_v(in_v), .in_a(in_a), .in_global_tag(in_global_tag),
    .in_tag(in_tag), .in_ct(in_ct),
    .out_v(out_v), .out_a(out_a), .out_dest(out_dest),
    .out_tag(out_tag), .out_ct(out_ct),
    .conf_we(conf_we), .conf_addr(conf_addr), .conf_mask(conf_mask),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: the fan-out table as written, and the saturating drop total.
  logic [3:0] tbl_m [256];
  int         drop_m;
  int         n_cmp;
  int         n_bad;

  typedef struct {
    logic [7:0]  gt;
    logic [3:0]  mask;
    logic [10:0] tag;
    logic [8:0]  ct;
    int          exp_copies;
    int          exp_first;
    int          exp_last;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [3:0] m);
    for (int i = 0; i < 4; i++) begin
      if (m[i]) return i;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) tbl_m[i] = 4'b0000;
    drop_m = 0;
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [3:0] m);
    conf_we   = 1'b1;
    conf_addr = a;
    conf_mask = m;
    step();
    conf_we   = 1'b0;
    tbl_m[a]  = m;
  endtask

  task automatic run_word(input logic [7:0] gt, input logic [10:0] tag, input logic [8:0] ct,
                          input int stall_pct, input int hold,
                          input bit coll, input logic [3:0] coll_mask,
                          output int n_copies, output int first_d, output int last_d);
    logic [3:0] exp_mask;
    logic [3:0] rem;
    int         cyc;
    int         guard;
    int         lo;
    n_copies = 0;
    first_d  = -1;
    last_d   = -1;
    guard    = 0;
    while (!in_a && guard < 100) begin
      step();
      guard++;
    end
    chk("accept_ready", 32'(in_a), 32'd1);
    in_v = 1'b1; in_global_tag = gt; in_tag = tag; in_ct = ct;
    step();
    in_v = 1'b0;
    exp_mask = tbl_m[gt];
    chk("lookup_in_a", 32'(in_a), 32'd0);
    chk("lookup_out_v", 32'(out_v), 32'd0);
    if (coll) begin
      conf_we = 1'b1; conf_addr = gt; conf_mask = coll_mask;
    end
    step();
    if (coll) begin
      conf_we = 1'b0;
      tbl_m[gt] = coll_mask;
    end
    if (exp_mask == 4'b0000) begin
      drop_m = (drop_m == DROP_MAX) ? DROP_MAX : drop_m + 1;
      chk("drop_in_a", 32'(in_a), 32'd1);
      chk("drop_out_v", 32'(out_v), 32'd0);
      chk("drop_count", 32'(drop_count), 32'(drop_m));
      return;
    end
    chk("latency_out_v", 32'(out_v), 32'd1);
    rem = exp_mask;
    for (int h = 0; h < hold; h++) begin
      in_v = 1'b1; in_global_tag = 8'h10;
      out_a = 1'b0;
      chk("hold_out_v", 32'(out_v), 32'd1);
      chk("hold_dest", 32'(out_dest), 32'(lowest(rem)));
      chk("hold_tag", 32'(out_tag), 32'(tag));
      chk("hold_ct", 32'(out_ct), 32'(ct));
      chk("hold_in_a", 32'(in_a), 32'd0);
      step();
    end
    in_v = 1'b0;
    cyc = 0;
    while (rem != 4'b0000 && cyc < 64) begin
      lo = lowest(rem);
      chk("emit_out_v", 32'(out_v), 32'd1);
      chk("emit_dest", 32'(out_dest), 32'(lo));
      chk("emit_tag", 32'(out_tag), 32'(tag));
      chk("emit_ct", 32'(out_ct), 32'(ct));
      chk("emit_in_a", 32'(in_a), 32'd0);
      out_a = ($urandom_range(99) >= 32'(stall_pct));
      step();
      cyc++;
      if (out_a) begin
        if (n_copies == 0) first_d = lo;
        last_d = lo;
        n_copies++;
        rem[lo] = 1'b0;
      end
    end
    out_a = 1'b0;
    chk("word_done", 32'(rem), 32'd0);
    chk("done_in_a", 32'(in_a), 32'd1);
    chk("done_out_v", 32'(out_v), 32'd0);
    if (stall_pct == 0) chk("consecutive", 32'(cyc), 32'($countones(exp_mask)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [7];
    int   n, f, l;

    n_cmp = 0; n_bad = 0;
    model_reset();
    reset = 1'b0; in_v = 1'b0; in_global_tag = '0; in_tag = '0; in_ct = '0;
    out_a = 1'b0; conf_we = 1'b0; conf_addr = '0; conf_mask = '0;

    vecs[0] = '{8'h05, 4'b1010, 11'h123, 9'h007, 2, 1, 3};
    vecs[1] = '{8'h01, 4'b0001, 11'h001, 9'h001, 1, 0, 0};
    vecs[2] = '{8'h02, 4'b1000, 11'h7FF, 9'h1FF, 1, 3, 3};
    vecs[3] = '{8'h03, 4'b0110, 11'h2AA, 9'h155, 2, 1, 2};
    vecs[4] = '{8'hFF, 4'b1111, 11'h555, 9'h0AA, 4, 0, 3};
    vecs[5] = '{8'h00, 4'b1101, 11'h000, 9'h000, 3, 0, 3};
    vecs[6] = '{8'h11, 4'b0000, 11'h3C3, 9'h0F0, 0, 0, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_a", 32'(in_a), 32'd1);
    chk("rst_out_v", 32'(out_v), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("post_rst_in_a", 32'(in_a), 32'd1);

    // Empty table: every word drops.
    for (int i = 0; i < 3; i++) begin
      run_word(8'h10, 11'(i), 9'(i), 0, 0, 1'b0, 4'b0000, n, f, l);
    end
    chk("three_drops", 32'(drop_count), 32'd3);

    for (int i = 0; i < 7; i++) begin
      cfg_write(vecs[i].gt, vecs[i].mask);
      run_word(vecs[i].gt, vecs[i].tag, vecs[i].ct, 0, 0, 1'b0, 4'b0000, n, f, l);
      chk("vec_copies", 32'(n), 32'(vecs[i].exp_copies));
      if (vecs[i].exp_copies > 0) begin
        chk("vec_first", 32'(f), 32'(vecs[i].exp_first));
        chk("vec_last", 32'(l), 32'(vecs[i].exp_last));
      end
    end

    // Backpressure: 5 stalled cycles with a competing input pending.
    cfg_write(8'h20, 4'b1111);
    run_word(8'h20, 11'h4A5, 9'h0C3, 0, 5, 1'b0, 4'b0000, n, f, l);
    chk("stall_copies", 32'(n), 32'd4);
    chk("stall_first", 32'(f), 32'd0);
    chk("stall_last", 32'(l), 32'd3);

    // Write during LOOKUP: current word sees old mask, next word sees new.
    cfg_write(8'h07, 4'b0001);
    run_word(8'h07, 11'h0AB, 9'h011, 0, 0, 1'b1, 4'b0100, n, f, l);
    chk("coll_cur_copies", 32'(n), 32'd1);
    chk("coll_cur_dest", 32'(f), 32'd0);
    run_word(8'h07, 11'h0AC, 9'h012, 0, 0, 1'b0, 4'b0000, n, f, l);
    chk("coll_next_copies", 32'(n), 32'd1);
    chk("coll_next_dest", 32'(f), 32'd2);

    // Randomized traffic with stalls against the model.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(99) < 30) begin
        cfg_write(8'($urandom_range(7)), 4'($urandom_range(15)));
      end else begin
        run_word(8'($urandom_range(7)), 11'($urandom), 9'($urandom),
                 30, 0, 1'b0, 4'b0000, n, f, l);
      end
    end
    chk("rand_drop", 32'(drop_count), 32'(drop_m));

    // Asynchronous reset after the first of three copies.
    cfg_write(8'h30, 4'b0111);
    in_v = 1'b1; in_global_tag = 8'h30; in_tag = 11'h111; in_ct = 9'h022;
    step();
    in_v = 1'b0;
    step();
    chk("mid_first_dest", 32'(out_dest), 32'd0);
    out_a = 1'b1;
    step();
    out_a = 1'b0;
    chk("mid_second_dest", 32'(out_dest), 32'd1);
    chk("mid_pre_drop", 32'(drop_count), 32'(drop_m));
    #2;
    reset = 1'b0;
    #1;
    chk("async_out_v", 32'(out_v), 32'd0);
    chk("async_drop", 32'(drop_count), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("release_in_a", 32'(in_a), 32'd1);
    chk("release_out_v", 32'(out_v), 32'd0);
    run_word(8'h30, 11'h001, 9'h001, 0, 0, 1'b0, 4'b0000, n, f, l);
    run_word(8'h20, 11'h002, 9'h002, 0, 0, 1'b0, 4'b0000, n, f, l);
    run_word(8'h05, 11'h003, 9'h003, 0, 0, 1'b0, 4'b0000, n, f, l);
    run_word(8'hFF, 11'h004, 9'h004, 0, 0, 1'b0, 4'b0000, n, f, l);
    chk("cleared_copies", 32'(n), 32'd0);

    // Drive the drop counter past its ceiling.
    for (int i = 0; i < DROP_MAX + 3 - 4; i++) begin
      run_word(8'($urandom_range(255)), 11'($urandom), 9'($urandom),
               0, 0, 1'b0, 4'b0000, n, f, l);
    end
    chk("drop_saturated", 32'(drop_count), 32'(DROP_MAX));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
